// File: rtl/rf_wport_arbiter.sv
// ============================================================================
// rf_wport_arbiter : round-robin arbiter sharing the register-file write port
//   Optional build macro: RFARB_FIXED_PRIO_EN (fixed lowest-index priority)
// Revision: 1.0
// ============================================================================
`default_nettype none

module rf_wport_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold_i,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NREQ*DATA_W-1:0]   req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic                     wEnable_o,
  output logic [ADDR_W-1:0]        wAddr_o,
  output logic [DATA_W-1:0]        wData_o,
  output logic [7:0]               conflict_cnt_o
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   w_grant;
  logic              w_any;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_contend;
  logic              w_wr;

  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        cnt_q, cnt_d;

`ifdef RFARB_FIXED_PRIO_EN
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    if (rst && !hold_i) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_any && req_valid_i[i]) begin
          w_any      = 1'b1;
          w_grant[i] = 1'b1;
          w_addr     = req_addr_i[i*ADDR_W +: ADDR_W];
          w_data     = req_data_i[i*DATA_W +: DATA_W];
        end
      end
    end
  end
`else
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] w_win;

  // Search order rotates so the index after the last winner is tried first.
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    w_win   = last_q;
    if (rst && !hold_i) begin
      for (int k = 1; k <= NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!w_any && req_valid_i[i] && (i == (int'(last_q) + k) % NREQ)) begin
            w_any      = 1'b1;
            w_grant[i] = 1'b1;
            w_win      = IDX_W'(i);
            w_addr     = req_addr_i[i*ADDR_W +: ADDR_W];
            w_data     = req_data_i[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= IDX_W'(NREQ - 1);
    end else if (w_any) begin
      last_q <= w_win;
    end
  end
`endif

  assign w_contend = !hold_i && ($countones(req_valid_i) > 1);
  assign w_wr      = w_any && (w_addr != '0);
  assign cnt_d     = (w_contend && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;

  // Zero-register grants are consumed without disturbing the held address/data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= 8'd0;
    end else begin
      wen_q <= w_wr;
      cnt_q <= cnt_d;
      if (w_wr) begin
        addr_q <= w_addr;
        data_q <= w_data;
      end
    end
  end

  assign req_ready_o    = w_grant;
  assign wEnable_o      = wen_q;
  assign wAddr_o        = addr_q;
  assign wData_o        = data_q;
  assign conflict_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wport_arbiter.sv
// ============================================================================
// tb_rf_wport_arbiter : scoreboard bench for rf_wport_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rf_wport_arbiter;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  logic                   clk;
  logic                   rst;
  logic                   hold_i;
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ*ADDR_W-1:0] req_addr_i;
  logic [NREQ*DATA_W-1:0] req_data_i;
  logic [NREQ-1:0]        req_ready_o;
  logic                   wEnable_o;
  logic [ADDR_W-1:0]      wAddr_o;
  logic [DATA_W-1:0]      wData_o;
  logic [7:0]             conflict_cnt_o;

  rf_wport_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .hold_i         (hold_i),
    .req_valid_i    (req_valid_i),
    .req_addr_i     (req_addr_i),
    .req_data_i     (req_data_i),
    .req_ready_o    (req_ready_o),
    .wEnable_o      (wEnable_o),
    .wAddr_o        (wAddr_o),
    .wData_o        (wData_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              wen;
    logic              ad_known;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                m_last;
  int                m_cnt;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              m_known;
  logic [NREQ-1:0]   last_grant;
  logic [ADDR_W-1:0] ta [NREQ];
  logic [DATA_W-1:0] td [NREQ];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      req_addr_i[i*ADDR_W +: ADDR_W] = ta[i];
      req_data_i[i*DATA_W +: DATA_W] = td[i];
    end
  endtask

  task automatic model_reset();
    m_last  = NREQ - 1;
    m_cnt   = 0;
    m_addr  = '0;
    m_data  = '0;
    m_known = 1'b1;
    sb_q.delete();
  endtask

  // One clock: predict the grant, push the expected output, check after the edge.
  task automatic cycle();
    int              win;
    logic [NREQ-1:0] eg;
    exp_t            e;
    exp_t            o;
    pack();
    #1;
    win = -1;
    eg  = '0;
    if (!hold_i) begin
`ifdef RFARB_FIXED_PRIO_EN
      for (int j = 0; j < NREQ; j++)
        if (win < 0 && req_valid_i[j]) win = j;
`else
      for (int off = 1; off <= NREQ; off++)
        if (win < 0 && req_valid_i[(m_last + off) % NREQ]) win = (m_last + off) % NREQ;
`endif
    end
    if (win >= 0) eg[win] = 1'b1;
    check("ready", 32'(req_ready_o), 32'(eg));
    if (!hold_i && $countones(req_valid_i) >= 2 && m_cnt < 255) m_cnt++;
    e.wen = 1'b0;
    if (win >= 0) begin
      if (ta[win] != '0) begin
        e.wen   = 1'b1;
        m_addr  = ta[win];
        m_data  = td[win];
        m_known = 1'b1;
      end else begin
        m_known = 1'b0;
      end
      m_last = win;
    end
    e.ad_known = m_known;
    e.addr     = m_addr;
    e.data     = m_data;
    sb_q.push_back(e);
    last_grant = eg;
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    check("wen", 32'(wEnable_o), 32'(o.wen));
    if (o.ad_known) begin
      check("waddr", 32'(wAddr_o), 32'(o.addr));
      check("wdata", 32'(wData_o), 32'(o.data));
    end
    check("cnt", 32'(conflict_cnt_o), 32'(m_cnt));
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b0;
    hold_i      = 1'b0;
    req_valid_i = '1;
    ta[0] = 4'd1; td[0] = 16'h0011;
    ta[1] = 4'd2; td[1] = 16'h0022;
    ta[2] = 4'd3; td[2] = 16'h0033;
    pack();
    model_reset();
    last_grant = '0;

    // Reset held with all requesters valid
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_wen",   32'(wEnable_o),   32'd0);
    check("rst_cnt",   32'(conflict_cnt_o), 32'd0);
    check("rst_waddr", 32'(wAddr_o),     32'd0);
    @(negedge clk);
    rst = 1'b1;

`ifdef RFARB_FIXED_PRIO_EN
    req_valid_i = 3'b110;
    repeat (5) begin
      cycle();
      check("fp_grant1", 32'(last_grant), 32'b010);
    end
`else
    // Round-robin over three contending requesters
    #1;
    check("first_grant", 32'(req_ready_o), 32'b001);
    repeat (6) cycle();
    check("rr_cnt6", 32'(conflict_cnt_o), 32'd6);

    // Write to register zero is consumed silently
    req_valid_i = 3'b010;
    ta[1] = 4'd0; td[1] = 16'hBEEF;
    cycle();
    check("zero_grant", 32'(last_grant), 32'b010);
    req_valid_i = '0;
    cycle();
    ta[1] = 4'd2; td[1] = 16'h0022;

    // Hold blocks grants; resume after last winner (1) -> requester 2
    req_valid_i = 3'b111;
    hold_i      = 1'b1;
    repeat (3) cycle();
    hold_i = 1'b0;
    #1;
    check("hold_resume", 32'(req_ready_o), 32'b100);
    cycle();

    // Single requester: granted every cycle, no contention
    req_valid_i = 3'b001;
    ta[0] = 4'd9; td[0] = 16'h1234;
    repeat (3) begin
      cycle();
      check("single_grant", 32'(last_grant), 32'b001);
    end
    req_valid_i = '0;
    cycle();
    check("idle_hold_addr", 32'(wAddr_o), 32'd9);

    // Random traffic obeying valid-until-ready
    req_valid_i = '0;
    last_grant  = '0;
    repeat (60) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid_i[i] || last_grant[i]) begin
          req_valid_i[i] = 1'($urandom_range(0, 1));
          ta[i] = ADDR_W'($urandom_range(0, 15));
          td[i] = DATA_W'($urandom);
        end
      end
      hold_i = ($urandom_range(0, 3) == 0);
      cycle();
    end
    hold_i = 1'b0;
`endif

    // Counter saturation
    req_valid_i = 3'b111;
    ta[0] = 4'd1; ta[1] = 4'd2; ta[2] = 4'd3;
    repeat (300) cycle();
    check("cnt_sat", 32'(conflict_cnt_o), 32'd255);

    // Asynchronous reset mid-operation drops the in-flight write
    req_valid_i = 3'b001;
    pack();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_wen",   32'(wEnable_o),      32'd0);
    check("midrst_cnt",   32'(conflict_cnt_o), 32'd0);
    check("midrst_ready", 32'(req_ready_o),    32'd0);
    check("midrst_waddr", 32'(wAddr_o),        32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cycle();
    check("post_rst_grant", 32'(last_grant), 32'b001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Shares the single register-file write port between several writeback requesters (pipeline WB stage, multi-cycle unit completion, interrupt/context-restore engine). Each cycle it accepts at most one write request through a valid/ready handshake, selects the winner round-robin, and drives a registered write enable, address and data to the register file's write port one cycle later. Writes to register zero are consumed and discarded. A saturating counter reports arbitration contention for performance debug.

## Interface
- `NREQ`, 3, number of requesters (2..8)
- `ADDR_W`, 4, register address width (matches register-file address bus)
- `DATA_W`, 16, register data width (matches register-file data bus)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `hold_i`  in  1  freeze: no grants this cycle
- `req_valid_i`  in  NREQ  per-requester write request
- `req_addr_i`  in  NREQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]
- `req_data_i`  in  NREQ*DATA_W  packed data, same packing
- `req_ready_o`  out  NREQ  one-hot grant; handshake completes when valid & ready
- `wEnable_o`  out  1  register-file write enable
- `wAddr_o`  out  ADDR_W  register-file write address
- `wData_o`  out  DATA_W  register-file write data
- `conflict_cnt_o`  out  8  saturating count of contended cycles

## Operation
- Requester holds valid, addr, data stable until it sees ready; dropping valid before ready is illegal (no effect on arbiter state).
- Grant: combinational from `req_valid_i`, `hold_i`, and pointer `last`; at most one bit of `req_ready_o` set; zero when `hold_i`=1 or `rst`=0.
- Round-robin: search starts at `(last+1) mod NREQ`, first valid index wins; `last` updates to winner only on a grant. Any waiting requester is granted within NREQ-1 intervening grants.
- Output stage (registered): on grant with address ≠ 0 → next cycle `wEnable_o`=1, `wAddr_o`/`wData_o` = winner's values. On grant to address 0 → request consumed, `wEnable_o`=0 next cycle. No grant → `wEnable_o`=0; `wAddr_o`/`wData_o` hold previous values.
- `conflict_cnt_o`: +1 on each cycle with ≥2 bits of `req_valid_i` set and `hold_i`=0; saturates at 255.
- Two requesters targeting the same address in one cycle: serialised in grant order; later grant overwrites in the register file.

## Timing
- Reset (`rst`=0, asynchronous): `wEnable_o`=0, `wAddr_o`=0, `wData_o`=0, `conflict_cnt_o`=0, `last`=NREQ-1 (requester 0 first after reset), `req_ready_o`=0.
- Reset asserted mid-operation: an accepted but not yet emitted write is lost; requesters re-present after release.
- Latency: accept at edge N → write visible on port in cycle N+1, committed by register file at edge N+2 (same-cycle read bypass in the register file covers cycle N+1).
- Throughput: one write per cycle with continuous requests.
- `hold_i` affects only grants; a write already in the output stage still issues.
- Single requester valid: granted every cycle, no counter increment.

## Configuration
- `RFARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins; `last` not maintained; starvation of high indices allowed.
- Undefined (default): round-robin as above.

## Test plan
- Reset: hold `rst`=0 with all valids high → `req_ready_o`=0, `wEnable_o`=0, counter 0; release, first grant goes to requester 0.
- Round-robin: valids 3'b111 for 6 cycles, addrs 1/2/3, data 0x0011/0x0022/0x0033 → grants 0,1,2,0,1,2; `wAddr_o` sequence 1,2,3,1,2,3 one cycle later; `conflict_cnt_o`=6.
- Zero register: requester 1 alone, addr 0, data 0xBEEF → `req_ready_o`=3'b010 for one cycle, `wEnable_o` stays 0.
- Hold: all valid, `hold_i`=1 for 3 cycles → no grants, counter unchanged, `wEnable_o`=0 after first cycle; on release, grant resumes at `last`+1.
- Saturation: 300 contended cycles → `conflict_cnt_o`=255.
- Fixed priority build with `RFARB_FIXED_PRIO_EN`: valids 3'b110 constant → requester 1 granted every cycle, requester 2 never.
